spi_slave_param: RTL and testbench
==================================

# spi_slave_param

Parametrised SPI slave front-end that sits between an external SPI master and the single-port RAM controller. It deserialises `WIDTH+2`-bit command frames (2-bit command plus `WIDTH`-bit payload) onto a parallel `rx_data`/`rx_valid` interface. It serialises RAM read data back on `MISO`. Compared with the fixed 10-bit slave, it adds a configurable payload width, single-cycle `rx_valid` pulses, command checking, abort detection and a read-data timeout.

## Interface
- `WIDTH`, default 8: payload bits per frame; the frame is `WIDTH+2` bits.
- `TIMEOUT`, default 15: maximum number of cycles to wait for `tx_valid` after a read-data request.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `SS_n` in 1: slave select, active low.
- `MOSI` in 1: serial data in, MSB first, sampled on each `clk` rising edge.
- `MISO` out 1: serial data out, MSB first.
- `rx_data` out `WIDTH+2`: received frame; `[WIDTH+1:WIDTH]` = command, `[WIDTH-1:0]` = payload.
- `rx_valid` out 1: one-cycle pulse; `rx_data` is valid in that cycle.
- `tx_data` in `WIDTH`: read data from the RAM.
- `tx_valid` in 1: `tx_data` valid; sampled only in `RD_WAIT`.
- `frame_err` out 1: one-cycle pulse on abort, command mismatch or timeout.
- `busy` out 1: high whenever the state is not `IDLE`.

## Operation
- **Commands:**
  - `00` write address.
  - `01` write data.
  - `10` read address.
  - `11` read data.
- **Internal state:** `addr_rcvd` flag; `cnt` bit counter of width `$clog2(WIDTH+2)`; tx shift register; wait counter.
- **Reset:**
  - State `IDLE`; `addr_rcvd`=0; counters 0.
  - Outputs `MISO`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0.
- **`SS_n` priority:** `SS_n`=1 sampled in any non-`IDLE` state forces `IDLE` on that edge. If the frame or TX was incomplete, `frame_err` pulses on the same edge.
- **FSM states and transitions:**
  - `IDLE`: `SS_n`=0 → `CHK_CMD`.
  - `CHK_CMD`: stores `MOSI` into `rx_data[WIDTH+1]` and loads `cnt`=`WIDTH+1`. Next state:
    - `MOSI`=0 → `WRITE`.
    - `MOSI`=1 and `!addr_rcvd` → `RD_ADDR`.
    - `MOSI`=1 and `addr_rcvd` → `RD_DATA`.
  - `WRITE`, `RD_ADDR`, `RD_DATA`: each edge stores `MOSI` into `rx_data[cnt-1]` and decrements `cnt`. On the edge that stores bit 0, the command check runs:
    - `WRITE` accepts `00` and `01`.
    - `RD_ADDR` requires `10`; on success it sets `addr_rcvd`.
    - `RD_DATA` requires `11`.
    - Pass → `rx_valid`=1 for one cycle. Fail → `frame_err`=1 for one cycle, no `rx_valid`.
    - Next state after a pass: `RD_DATA` → `RD_WAIT` with wait counter=0; `WRITE`/`RD_ADDR` → `DONE`. After a fail: `DONE`.
  - `RD_WAIT`: on `tx_valid`=1, loads `tx_data` into the shift register and moves to `TX` with `cnt`=`WIDTH`. Otherwise the wait counter increments. When it reaches `TIMEOUT`: `frame_err` pulses, `addr_rcvd` clears, state → `DONE`.
  - `TX`: each edge drives `MISO` with `shift[cnt-1]` and decrements `cnt`. After bit 0 is driven, the next edge sets `MISO`=0, clears `addr_rcvd` and moves to `DONE`.
  - `DONE`: ignores `MOSI`, `MISO`=0, waits for `SS_n`=1.
- **Abort behaviour:** an abort leaves `addr_rcvd` unchanged, so the master may retry a read-data frame. `rx_data` keeps its last value on abort.
- `MISO`=0 in every state except `TX`.

## Timing
- Edge 0 samples `SS_n`=0 in `IDLE`. Edge 1 samples command bit `WIDTH+1`. Edges 2..`WIDTH+2` sample the remaining bits.
- `rx_valid` and the final `rx_data` are registered on edge `WIDTH+2` and are visible in the following cycle only.
- Read data: `tx_valid` sampled at edge t → `MISO`=`tx_data[WIDTH-1]` from edge t+1, one bit per cycle, LSB visible after edge t+`WIDTH`.
- The `RD_WAIT` timeout fires on the `TIMEOUT`-th consecutive edge with `tx_valid`=0.
- `SS_n`=1 and frame completion on the same edge: completion wins (`rx_valid` pulses, no `frame_err`), then `IDLE`.
- `rst`=1 on any edge overrides everything, including mid-`TX`; all outputs are 0 on the next cycle.
- Back-to-back frames: `SS_n` high for a minimum of 1 cycle.

## Test plan
- Write address, `WIDTH`=8, frame `00_1010_0101` → `rx_data`=0x0A5, `rx_valid` high for exactly 1 cycle after edge 10, `frame_err`=0, state `DONE` until `SS_n` rises.
- Read address `10_0001_0000`, then read data `11_xxxx_xxxx` with `tx_valid`=1 and `tx_data`=0xC3 two cycles after `rx_valid` → `MISO` sequence 1,1,0,0,0,0,1,1, then 0; `addr_rcvd` cleared.
- `SS_n` raised after 5 bits of a write frame → `frame_err` pulse on that edge, no `rx_valid`, `IDLE` next, `busy`=0.
- Read-data frame with `tx_valid` held 0 → `frame_err` after exactly 15 cycles in `RD_WAIT`; the next read frame is decoded as `RD_ADDR`.
- `addr_rcvd`=1 and frame `10_...` (MOSI=1 routes to `RD_DATA`) → command mismatch, `frame_err` pulse, no `rx_valid`.
- `rst`=1 for one cycle during `TX` bit 4 → next cycle `MISO`=0, `rx_valid`=0, `busy`=0, `addr_rcvd`=0; `WIDTH`=16 write frame afterwards yields `rx_valid` after edge 18.

Source files
------------

// File: rtl/spi_slave_param.sv
// SPI slave front-end: deserialises WIDTH+2 bit command frames onto rx_data/rx_valid and
// serialises RAM read data on MISO, with command checking, abort detection and read timeout.
module spi_slave_param #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SS_n,
    input  logic             MOSI,
    output logic             MISO,
    output logic [WIDTH+1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned CntW  = $clog2(WIDTH + 2);
    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StChkCmd,
        StWrite,
        StRdAddr,
        StRdData,
        StRdWait,
        StTx,
        StDone
    } state_e;

    state_e            state_q;
    logic              addr_rcvd_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  shift_q;
    logic [WaitW-1:0]  wait_cnt_q;

    logic [1:0] cmd;
    logic       cmd_ok;
    logic       in_frame;
    logic       last_bit;
    logic       tx_done;

    // Command bits are already captured by the time the final payload bit arrives.
    always_comb begin
        cmd      = rx_data[WIDTH+1:WIDTH];
        in_frame = (state_q == StWrite) || (state_q == StRdAddr) || (state_q == StRdData);
        last_bit = in_frame && (cnt_q == CntOne);
        tx_done  = (state_q == StTx) && (cnt_q == '0);
        cmd_ok   = 1'b0;
        case (state_q)
            StWrite:  cmd_ok = (cmd[1] == 1'b0);
            StRdAddr: cmd_ok = (cmd == 2'b10);
            StRdData: cmd_ok = (cmd == 2'b11);
            default:  cmd_ok = 1'b0;
        endcase
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_rcvd_q <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            wait_cnt_q  <= '0;
            MISO        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if ((state_q != StIdle) && SS_n) begin
                // Deselect: a frame finishing on this same edge still completes normally.
                state_q <= StIdle;
                MISO    <= 1'b0;
                if (last_bit) begin
                    rx_data[0] <= MOSI;
                    rx_valid   <= cmd_ok;
                    frame_err  <= !cmd_ok;
                    if (cmd_ok && (state_q == StRdAddr)) begin
                        addr_rcvd_q <= 1'b1;
                    end
                end else if ((state_q != StDone) && !tx_done) begin
                    frame_err <= 1'b1;
                end
            end else begin
                case (state_q)
                    StIdle: begin
                        MISO <= 1'b0;
                        if (!SS_n) begin
                            state_q <= StChkCmd;
                        end
                    end
                    StChkCmd: begin
                        rx_data[WIDTH+1] <= MOSI;
                        cnt_q            <= CntW'(WIDTH + 1);
                        if (!MOSI) begin
                            state_q <= StWrite;
                        end else if (!addr_rcvd_q) begin
                            state_q <= StRdAddr;
                        end else begin
                            state_q <= StRdData;
                        end
                    end
                    StWrite, StRdAddr, StRdData: begin
                        rx_data[cnt_q - CntOne] <= MOSI;
                        cnt_q                   <= cnt_q - CntOne;
                        if (cnt_q == CntOne) begin
                            if (cmd_ok) begin
                                rx_valid <= 1'b1;
                                if (state_q == StRdAddr) begin
                                    addr_rcvd_q <= 1'b1;
                                end
                                if (state_q == StRdData) begin
                                    wait_cnt_q <= '0;
                                    state_q    <= StRdWait;
                                end else begin
                                    state_q <= StDone;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                state_q   <= StDone;
                            end
                        end
                    end
                    StRdWait: begin
                        MISO <= 1'b0;
                        if (tx_valid) begin
                            shift_q <= tx_data;
                            cnt_q   <= CntW'(WIDTH);
                            state_q <= StTx;
                        end else if (wait_cnt_q == WaitW'(TIMEOUT - 1)) begin
                            frame_err   <= 1'b1;
                            addr_rcvd_q <= 1'b0;
                            state_q     <= StDone;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + WaitW'(1);
                        end
                    end
                    StTx: begin
                        if (cnt_q != '0) begin
                            MISO    <= shift_q[WIDTH-1];
                            shift_q <= shift_q << 1;
                            cnt_q   <= cnt_q - CntOne;
                        end else begin
                            MISO        <= 1'b0;
                            addr_rcvd_q <= 1'b0;
                            state_q     <= StDone;
                        end
                    end
                    StDone: begin
                        MISO <= 1'b0;
                    end
                    default: begin
                        MISO    <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed self-checking bench for spi_slave_param at WIDTH=8 and WIDTH=16.
module tb_spi_slave_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        ss_n;
    logic        mosi;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        miso;
    logic [9:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;

    logic        ss16;
    logic        mosi16;
    logic [15:0] tx16;
    logic        txv16;
    logic        miso16;
    logic [17:0] rxd16;
    logic        rxv16;
    logic        ferr16;
    logic        busy16;

    int checks = 0;
    int errors = 0;

    spi_slave_param #(.WIDTH(8), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (ss_n),
        .MOSI      (mosi),
        .MISO      (miso),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    spi_slave_param #(.WIDTH(16), .TIMEOUT(15)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (ss16),
        .MOSI      (mosi16),
        .MISO      (miso16),
        .rx_data   (rxd16),
        .rx_valid  (rxv16),
        .tx_data   (tx16),
        .tx_valid  (txv16),
        .frame_err (ferr16),
        .busy      (busy16)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Selects the slave and shifts a full 10-bit frame; leaves SS_n low.
    task automatic send8(input logic [9:0] f);
        ss_n = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            mosi = f[i];
            tick();
        end
    endtask

    task automatic end8();
        ss_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0]  exp_byte;
        logic [9:0]  f;
        logic [17:0] f16;

        rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_data = '0; tx_valid = 1'b0;
        ss16 = 1'b1; mosi16 = 1'b0; tx16 = '0; txv16 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_miso", 32'(miso), 32'h0);
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        // Write address 00_1010_0101
        send8(10'h0A5);
        check("wa_rx_valid", 32'(rx_valid), 32'h1);
        check("wa_rx_data", 32'(rx_data), 32'h0A5);
        check("wa_frame_err", 32'(frame_err), 32'h0);
        tick();
        check("wa_rx_valid_pulse", 32'(rx_valid), 32'h0);
        check("wa_busy_done", 32'(busy), 32'h1);
        tick();
        check("wa_busy_done2", 32'(busy), 32'h1);
        end8();
        check("wa_idle", 32'(busy), 32'h0);

        // Read address then read data with tx_data 0xC3
        send8(10'h210);
        check("ra_rx_valid", 32'(rx_valid), 32'h1);
        check("ra_rx_data", 32'(rx_data), 32'h210);
        end8();
        send8(10'h300);
        check("rd_rx_valid", 32'(rx_valid), 32'h1);
        check("rd_rx_data", 32'(rx_data), 32'h300);
        tick();
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        tick();
        tx_valid = 1'b0;
        check("rd_miso_pre", 32'(miso), 32'h0);
        exp_byte = 8'hC3;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rd_miso_bit", 32'(miso), 32'(exp_byte[7-k]));
        end
        tick();
        check("rd_miso_after", 32'(miso), 32'h0);
        check("rd_busy_done", 32'(busy), 32'h1);
        end8();

        // addr_rcvd cleared after TX: 10_ frame decodes as read address
        send8(10'h201);
        check("ra2_rx_valid", 32'(rx_valid), 32'h1);
        check("ra2_frame_err", 32'(frame_err), 32'h0);
        end8();

        // addr_rcvd set: 10_ frame routes to read-data and mismatches
        send8(10'h202);
        check("mis_frame_err", 32'(frame_err), 32'h1);
        check("mis_rx_valid", 32'(rx_valid), 32'h0);
        tick();
        check("mis_err_pulse", 32'(frame_err), 32'h0);
        end8();

        // Read-data timeout with tx_valid held low
        send8(10'h300);
        check("to_rx_valid", 32'(rx_valid), 32'h1);
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        check("to_not_yet", 32'(frame_err), 32'h0);
        tick();
        check("to_frame_err", 32'(frame_err), 32'h1);
        tick();
        check("to_err_pulse", 32'(frame_err), 32'h0);
        check("to_busy_done", 32'(miso), 32'h0);
        end8();
        send8(10'h2F0);
        check("to_next_ra", 32'(rx_valid), 32'h1);
        check("to_next_ra_data", 32'(rx_data), 32'h2F0);
        end8();

        // Abort a write frame after 5 bits
        f = 10'h0A5;
        ss_n = 1'b0;
        tick();
        for (int i = 9; i >= 5; i--) begin
            mosi = f[i];
            tick();
        end
        ss_n = 1'b1;
        tick();
        check("ab_frame_err", 32'(frame_err), 32'h1);
        check("ab_rx_valid", 32'(rx_valid), 32'h0);
        check("ab_busy", 32'(busy), 32'h0);
        tick();
        check("ab_err_pulse", 32'(frame_err), 32'h0);

        // Deselect on the completing edge: completion wins
        f = 10'h13C;
        ss_n = 1'b0;
        tick();
        for (int i = 9; i >= 1; i--) begin
            mosi = f[i];
            tick();
        end
        mosi = f[0];
        ss_n = 1'b1;
        tick();
        check("se_rx_valid", 32'(rx_valid), 32'h1);
        check("se_frame_err", 32'(frame_err), 32'h0);
        check("se_rx_data", 32'(rx_data), 32'h13C);
        check("se_busy", 32'(busy), 32'h0);
        tick();
        check("se_pulse", 32'(rx_valid), 32'h0);

        // Reset in the middle of TX (addr_rcvd is set from the 0x2F0 frame)
        send8(10'h300);
        check("rs_rx_valid", 32'(rx_valid), 32'h1);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        check("rs_miso_bit5", 32'(miso), 32'h1);
        rst  = 1'b1;
        ss_n = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_miso", 32'(miso), 32'h0);
        check("rs_rx_valid0", 32'(rx_valid), 32'h0);
        check("rs_busy", 32'(busy), 32'h0);
        check("rs_frame_err", 32'(frame_err), 32'h0);
        // addr_rcvd cleared: 11_ frame goes to read-address and mismatches
        send8(10'h3AA);
        check("rs_addr_clr_err", 32'(frame_err), 32'h1);
        check("rs_addr_clr_valid", 32'(rx_valid), 32'h0);
        end8();

        // WIDTH=16 write-data frame
        f16 = 18'h1BEEF;
        ss16 = 1'b0;
        tick();
        for (int i = 17; i >= 0; i--) begin
            mosi16 = f16[i];
            tick();
            if (i == 1) begin
                check("w16_early", 32'(rxv16), 32'h0);
            end
        end
        check("w16_rx_valid", 32'(rxv16), 32'h1);
        check("w16_rx_data", 32'(rxd16), 32'h1BEEF);
        check("w16_frame_err", 32'(ferr16), 32'h0);
        ss16 = 1'b1;
        tick();
        check("w16_idle", 32'(busy16), 32'h0);
        check("w16_pulse", 32'(rxv16), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
